rr_burst_arbiter: RTL and testbench
===================================

# rr_burst_arbiter

Round-robin arbiter that shares a single downstream resource port among N requesters, holding each grant for a burst of up to MAX_BEATS accepted beats. A requester that has just owned the port drops to lowest priority, so every active requester is served in turn. It sits between the requester-side request lines and the shared resource's ready signal, and it drives the mux select for the shared datapath.

## Interface
- N, 4, number of requesters (2..16)
- MAX_BEATS, 8, maximum accepted beats per grant (1..2^CNT_W)
- CNT_W, 4, width of the beat counter; must satisfy 2^CNT_W >= MAX_BEATS
- clk  input  1  clock; all state updates on the rising edge
- rst  input  1  reset, asynchronous, active-high
- req  input  N  per-requester request; held high for as long as that requester has beats to send
- res_ready  input  1  shared resource accepts a beat this cycle
- grant  output  N  one-hot owner of the port; all zero when no owner
- grant_id  output  max(1,$clog2(N))  binary index of the owner; holds its last value when grant_valid=0
- grant_valid  output  1  a grant is active (equals |grant)
- beat_cnt  output  CNT_W  number of beats accepted in the current grant

## Operation
- Two states: IDLE and BUSY.
- Internal rotating pointer ptr (index width). Reset value is 0.
- A beat is accepted in a cycle when state=BUSY, req[grant_id]=1 and res_ready=1.
- IDLE behaviour:
  - If req=0, stay in IDLE.
  - Otherwise, select the first set req bit searching ptr, ptr+1, ..., N-1, 0, ..., ptr-1 (modulo N).
  - Register grant, grant_id and grant_valid=1, clear beat_cnt, and go to BUSY.
- BUSY, release conditions (evaluated each cycle):
  - (a) req[grant_id]=0, or
  - (b) a beat is accepted and beat_cnt=MAX_BEATS-1.
- BUSY, on release at the clock edge:
  - Clear grant and grant_valid, and clear beat_cnt.
  - Set ptr to grant_id+1 modulo N, wrapping from N-1 to 0.
  - Go to IDLE.
- BUSY, otherwise: increment beat_cnt on each accepted beat and keep the same owner.
- Requests from non-owners never preempt the current owner.
- req changes on non-owner bits while in BUSY have no effect until the next IDLE cycle.
- If the sole active requester is released, it is re-granted after the mandatory IDLE cycle, because the wrap search reaches it.
- Reset values: state=IDLE, ptr=0, grant=0, grant_id=0, grant_valid=0, beat_cnt=0.
- Reset mid-burst: on rst assertion all outputs immediately take their reset values (asynchronous), with no completion of the burst. After rst deasserts, arbitration restarts from ptr=0.

## Timing
- Grant latency: req seen in IDLE at edge k, so grant is visible after edge k (1 cycle from req high).
- Grant outputs are registered; there is no combinational path from req or res_ready to any output.
- Release takes effect at the edge where the release condition is true. grant_valid is low for at least 1 cycle between consecutive grants.
- Burst length: with res_ready held at 1, a grant lasts exactly MAX_BEATS cycles.
- Total period per burst is MAX_BEATS+1 cycles, including the IDLE gap.
- Backpressure: cycles with res_ready=0 extend the grant and leave beat_cnt unchanged.
- The final beat and an owner req drop in the same cycle: the beat is not accepted (req=0), and release happens through condition (a).

## Test plan
- Reset: assert rst mid-simulation with req=1111.
  - Required: grant=0000, grant_id=0, grant_valid=0 and beat_cnt=0 immediately, without waiting for a clock edge.
  - Required: first grant after release is 0001.
- Single requester: N=4, MAX_BEATS=8, req=0100 held, res_ready=1.
  - Required: grant=0100 for 8 cycles with beat_cnt 0..7.
  - Required: then 1 cycle of grant=0000, then grant=0100 again.
- Full rotation: req=1111 held, res_ready=1.
  - Required: grant sequence 0001, 0010, 0100, 1000, 0001, each lasting 8 cycles with a 1-cycle gap between them.
  - Required: grant_id sequence 0, 1, 2, 3, 0.
- Backpressure: req=0010, res_ready pattern 1,0,0,1,1,0,...
  - Required: beat_cnt increments only on ready cycles.
  - Required: release occurs only after the 8th accepted beat.
- Early drop and priority rotation: req=0011; owner 0 drops req[0] after 3 beats.
  - Required: grant clears at that edge and beat_cnt returns to 0.
  - Required: next grant=0010. After requester 1's burst, with req[0] reasserted, the next grant is 0001.
- Non-preemption: owner 2 is mid-burst and req[0] rises.
  - Required: grant stays 0100 until release.
  - Required: next grant goes to requester 3 if req[3]=1, else to requester 0.

Source files
------------

// File: rtl/rr_burst_arbiter_if.sv
// Requester-side bundle for rr_burst_arbiter: request lines, shared-resource ready,
// and the registered grant/select outputs.
interface rr_burst_arbiter_if #(
  parameter int N     = 4,
  parameter int CNT_W = 4
);
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

  // Handshake: a beat transfers at a rising edge when grant_valid=1,
  // req[grant_id]=1 and res_ready=1; req is held high while beats remain.
  logic [N-1:0]     req;
  logic             res_ready;
  logic [N-1:0]     grant;
  logic [IDX_W-1:0] grant_id;
  logic             grant_valid;
  logic [CNT_W-1:0] beat_cnt;

  modport master (
    output req, res_ready,
    input  grant, grant_id, grant_valid, beat_cnt
  );

  modport slave (
    input  req, res_ready,
    output grant, grant_id, grant_valid, beat_cnt
  );
endinterface

// File: rtl/rr_burst_arbiter.sv
// Round-robin burst arbiter: one owner at a time for up to MAX_BEATS accepted beats,
// last owner drops to lowest priority, one IDLE cycle between grants.
module rr_burst_arbiter #(
  parameter int N         = 4,
  parameter int MAX_BEATS = 8,
  parameter int CNT_W     = 4
) (
  input  logic                clk,
  input  logic                rst,
  rr_burst_arbiter_if.slave   bus,
  output logic                state_dbg
);
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  state_t           state;
  logic [IDX_W-1:0] ptr;
  logic [IDX_W-1:0] pick_id;
  logic             pick_found;
  logic             owner_req;
  logic             accept;
  logic             release_now;
  logic [IDX_W-1:0] ptr_next;

  // Wrap-around search starting at ptr; first set request wins.
  always_comb begin
    int j;
    pick_found = 1'b0;
    pick_id    = '0;
    j          = 0;
    for (int i = 0; i < N; i++) begin
      j = (int'(ptr) + i) % N;
      if (!pick_found && bus.req[j]) begin
        pick_found = 1'b1;
        pick_id    = IDX_W'(j);
      end
    end
  end

  assign owner_req   = bus.req[bus.grant_id];
  assign accept      = (state == BUSY) && owner_req && bus.res_ready;
  assign release_now = (state == BUSY) &&
                       (!owner_req || (accept && bus.beat_cnt == CNT_W'(MAX_BEATS - 1)));
  assign ptr_next    = (bus.grant_id == IDX_W'(N - 1)) ? '0 : bus.grant_id + 1'b1;
  assign state_dbg   = (state == BUSY);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= IDLE;
      ptr             <= '0;
      bus.grant       <= '0;
      bus.grant_id    <= '0;
      bus.grant_valid <= 1'b0;
      bus.beat_cnt    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_found) begin
            state           <= BUSY;
            bus.grant       <= N'(1) << pick_id;
            bus.grant_id    <= pick_id;
            bus.grant_valid <= 1'b1;
            bus.beat_cnt    <= '0;
          end
        end
        BUSY: begin
          // grant_id is kept on release so the shared mux select stays stable.
          if (release_now) begin
            state           <= IDLE;
            bus.grant       <= '0;
            bus.grant_valid <= 1'b0;
            bus.beat_cnt    <= '0;
            ptr             <= ptr_next;
          end else if (accept) begin
            bus.beat_cnt <= bus.beat_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_rr_burst_arbiter.sv
// Bench for rr_burst_arbiter: vector table replayed through an expected-value queue,
// plus hand-written sequences for asynchronous reset mid-burst.
module tb_rr_burst_arbiter;
  localparam int N         = 4;
  localparam int MAX_BEATS = 8;
  localparam int CNT_W     = 4;
  localparam int IDX_W     = 2;
  localparam int EW        = N + IDX_W + CNT_W + 2;

  logic clk = 1'b0;
  logic rst;
  logic state_dbg;

  rr_burst_arbiter_if #(.N(N), .CNT_W(CNT_W)) bus ();

  rr_burst_arbiter #(.N(N), .MAX_BEATS(MAX_BEATS), .CNT_W(CNT_W)) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic             rst;
    logic [N-1:0]     req;
    logic             rdy;
    logic [N-1:0]     g;
    logic [IDX_W-1:0] id;
    logic             v;
    logic [CNT_W-1:0] cnt;
    int               ph;
  } vec_t;

  vec_t            vecs[$];
  logic [EW-1:0]   exp_q[$];
  int              checks = 0;
  int              errors = 0;
  string           ph_name[7] = '{"reset", "single", "rotation", "backpressure",
                                  "early_drop", "nonpreempt_r3", "nonpreempt_r0"};
  bit              bp_pat[6]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};

  function automatic logic [N-1:0] oh(int i);
    return N'(1) << i;
  endfunction

  function automatic void add(logic r, logic [N-1:0] rq, logic rd, logic [N-1:0] g,
                              int id, logic v, int cnt, int ph);
    vec_t x;
    x.rst = r; x.req = rq; x.rdy = rd; x.g = g;
    x.id = IDX_W'(id); x.v = v; x.cnt = CNT_W'(cnt); x.ph = ph;
    vecs.push_back(x);
  endfunction

  function automatic void add_rst(int ph);
    add(1'b1, '0, 1'b0, '0, 0, 1'b0, 0, ph);
  endfunction

  function automatic void push_exp(logic [N-1:0] g, int id, logic v, int cnt);
    exp_q.push_back({g, IDX_W'(id), v, CNT_W'(cnt), v});
  endfunction

  task automatic compare(string tag, int idx);
    logic [EW-1:0] a;
    logic [EW-1:0] e;
    a = {bus.grant, bus.grant_id, bus.grant_valid, bus.beat_cnt, state_dbg};
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL %s[%0d]: no expected entry queued", tag, idx);
    end else begin
      e = exp_q.pop_front();
      if (a !== e) begin
        errors++;
        $display("FAIL %s[%0d]: got grant=%b id=%0d valid=%b cnt=%0d busy=%b, expected grant=%b id=%0d valid=%b cnt=%0d busy=%b",
                 tag, idx, a[11:8], a[7:6], a[5], a[4:1], a[0],
                 e[11:8], e[7:6], e[5], e[4:1], e[0]);
      end
    end
  endtask

  task automatic build_vectors();
    int cnt_e;
    int acc;
    int k;
    bit rd;
    // single requester, with an idle no-request cycle first
    add_rst(1);
    add(0, 4'b0000, 1, '0, 0, 0, 0, 1);
    add(0, 4'b0100, 1, oh(2), 2, 1, 0, 1);
    for (int e = 1; e < MAX_BEATS; e++) add(0, 4'b0100, 1, oh(2), 2, 1, e, 1);
    add(0, 4'b0100, 1, '0, 2, 0, 0, 1);
    add(0, 4'b0100, 1, oh(2), 2, 1, 0, 1);
    add(0, 4'b0000, 1, '0, 2, 0, 0, 1);
    // full rotation
    add_rst(2);
    for (int b = 0; b < 5; b++) begin
      add(0, 4'b1111, 1, oh(b % N), b % N, 1, 0, 2);
      for (int e = 1; e < MAX_BEATS; e++) add(0, 4'b1111, 1, oh(b % N), b % N, 1, e, 2);
      add(0, 4'b1111, 1, '0, b % N, 0, 0, 2);
    end
    // backpressure
    add_rst(3);
    add(0, 4'b0010, 0, oh(1), 1, 1, 0, 3);
    cnt_e = 0; acc = 0; k = 0;
    while (acc < MAX_BEATS) begin
      rd = bp_pat[k % 6];
      k++;
      if (rd) acc++;
      if (rd && acc == MAX_BEATS) add(0, 4'b0010, rd, '0, 1, 0, 0, 3);
      else begin
        if (rd) cnt_e++;
        add(0, 4'b0010, rd, oh(1), 1, 1, cnt_e, 3);
      end
    end
    // early drop by owner 0 after 3 beats, then rotation back to 0
    add_rst(4);
    add(0, 4'b0011, 1, oh(0), 0, 1, 0, 4);
    for (int e = 1; e <= 3; e++) add(0, 4'b0011, 1, oh(0), 0, 1, e, 4);
    add(0, 4'b0010, 1, '0, 0, 0, 0, 4);
    add(0, 4'b0010, 1, oh(1), 1, 1, 0, 4);
    for (int e = 1; e < MAX_BEATS; e++) add(0, 4'b0011, 1, oh(1), 1, 1, e, 4);
    add(0, 4'b0011, 1, '0, 1, 0, 0, 4);
    add(0, 4'b0011, 1, oh(0), 0, 1, 0, 4);
    // non-preemption: next goes to 3 when requesting, else wraps to 0
    for (int p = 5; p <= 6; p++) begin
      add_rst(p);
      add(0, 4'b0100, 1, oh(2), 2, 1, 0, p);
      for (int e = 1; e < MAX_BEATS; e++) add(0, 4'b0101, 1, oh(2), 2, 1, e, p);
      add(0, (p == 5) ? 4'b1101 : 4'b0101, 1, '0, 2, 0, 0, p);
      add(0, (p == 5) ? 4'b1101 : 4'b0101, 1, oh((p == 5) ? 3 : 0), (p == 5) ? 3 : 0, 1, 0, p);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1;
    bus.req = '0;
    bus.res_ready = 1'b0;
    #1;
    push_exp('0, 0, 0, 0);
    compare("reset_init", 0);
    @(posedge clk); #1;
    rst = 1'b0;

    build_vectors();
    for (int k = 0; k < vecs.size(); k++) begin
      rst           = vecs[k].rst;
      bus.req       = vecs[k].req;
      bus.res_ready = vecs[k].rdy;
      push_exp(vecs[k].g, int'(vecs[k].id), vecs[k].v, int'(vecs[k].cnt));
      @(posedge clk); #1;
      compare(ph_name[vecs[k].ph], k);
    end

    // asynchronous reset in the middle of requester 1's burst
    rst = 1'b1;
    bus.req = 4'b1111;
    bus.res_ready = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    for (int e = 1; e <= 12; e++) begin
      if (e <= MAX_BEATS)          push_exp(oh(0), 0, 1, e - 1);
      else if (e == MAX_BEATS + 1) push_exp('0, 0, 0, 0);
      else                         push_exp(oh(1), 1, 1, e - MAX_BEATS - 2);
      @(posedge clk); #1;
      compare("pre_async", e);
    end
    #3;
    rst = 1'b1;
    #1;
    push_exp('0, 0, 0, 0);
    compare("async_reset", 0);
    @(posedge clk); #1;
    push_exp('0, 0, 0, 0);
    compare("async_reset_held", 0);
    rst = 1'b0;
    push_exp(oh(0), 0, 1, 0);
    @(posedge clk); #1;
    compare("first_after_reset", 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
